pinmux_wkup_detect: RTL

Single-channel pad wakeup detector on the pinmux MIO input path. It selects one of the raw `mio_in_i` pads and runs it through a 2-flop synchronizer and an optional glitch filter. An edge or timed-level detector then raises a sticky wakeup request for the power manager. It observes the same pad bus the pinmux input muxing consumes and is instantiated next to pinmux, fed by the same `mio_in_i` signals.

---
 rtl/pinmux_wkup_detect.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pinmux_wkup_detect.sv
// rtl/pinmux_wkup_detect.sv - single-channel MIO pad wakeup detector (optional glitch filter: PINMUX_WKUP_FILTER_EN)
module pinmux_wkup_detect #(
  parameter int NPads    = 32,
  parameter int CntWidth = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [NPads-1:0]         mio_in_i,
  input  logic [$clog2(NPads)-1:0] pad_sel_i,
  input  logic                     en_i,
  input  logic [2:0]               mode_i,
  input  logic [CntWidth-1:0]      cnt_th_i,
  input  logic                     clr_i,
  output logic                     wkup_req_o,
  output logic                     filt_val_o
);

  typedef enum logic [2:0] {
    StIdle  = 3'b001,
    StArmed = 3'b010,
    StFired = 3'b100
  } state_e;

  state_e              state_q;
  logic                s1_q, s2_q, prev_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                pad_mux, val, rise, fall, timed, lvl, det;

  assign pad_mux = mio_in_i[pad_sel_i];

  // Two-flop synchronizer for the asynchronous pad plus the previous-value tracker for edges.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= pad_mux;
      s2_q   <= s1_q;
      prev_q <= val;
    end
  end

`ifdef PINMUX_WKUP_FILTER_EN
  logic       filt_q;
  logic [1:0] fcnt_q;

  // Glitch filter: adopt s2 only after it has disagreed with filt on 4 consecutive samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      filt_q <= 1'b0;
      fcnt_q <= 2'd0;
    end else if (s2_q == filt_q) begin
      fcnt_q <= 2'd0;
    end else if (fcnt_q == 2'd3) begin
      filt_q <= s2_q;
      fcnt_q <= 2'd0;
    end else begin
      fcnt_q <= fcnt_q + 2'd1;
    end
  end

  assign val = filt_q;
`else
  assign val = s2_q;
`endif

  assign filt_val_o = val;

  assign rise  = val & ~prev_q;
  assign fall  = ~val & prev_q;
  assign timed = (mode_i == 3'd4) || (mode_i == 3'd5);
  assign lvl   = (mode_i == 3'd4) ? val : ~val;

  // Detection term for the selected mode; reserved modes never detect.
  always_comb begin
    det = 1'b0;
    case (mode_i)
      3'd1:       det = rise;
      3'd2:       det = fall;
      3'd3:       det = rise | fall;
      3'd4, 3'd5: det = lvl && (cnt_q == cnt_th_i);
      default:    det = 1'b0;
    endcase
  end

  // Timed-level run length: counts enabled ARMED cycles at the target level, saturating; zero otherwise.
  always_comb begin
    cnt_d = '0;
    if ((state_q == StArmed) && en_i && timed && lvl) begin
      cnt_d = (cnt_q == {CntWidth{1'b1}}) ? cnt_q : cnt_q + CntWidth'(1);
    end
  end

  // Detector FSM; a clear in ARMED suppresses a coincident detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      case (state_q)
        StIdle: begin
          if (en_i) state_q <= StArmed;
        end
        StArmed: begin
          if (!en_i) state_q <= StIdle;
          else if (det && !clr_i) state_q <= StFired;
        end
        StFired: begin
          if (clr_i) state_q <= en_i ? StArmed : StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign wkup_req_o = state_q[2];

endmodule
